// File: rtl/joy_fourway_filter.sv
// Four-way joystick restrictor: collapses an SOCD-cleaned {up,down,left,right}
// input to at most one direction, with selectable diagonal policy and dwell hold.
//
// state    | meaning
// ---------+-------------------------------------------
// ST_IDLE  | no direction asserted on diroutput
// ST_UP    | diroutput = 4'b1000
// ST_DOWN  | diroutput = 4'b0100
// ST_LEFT  | diroutput = 4'b0010
// ST_RIGHT | diroutput = 4'b0001
module joy_fourway_filter #(
    parameter logic [1:0] MODE  = 2'd0,
    parameter logic [7:0] DWELL = 8'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       enable,
    input  logic [3:0] dirinput,
    output logic [3:0] diroutput,
    output logic       diagonal
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_UP    = 3'd1,
        ST_DOWN  = 3'd2,
        ST_LEFT  = 3'd3,
        ST_RIGHT = 3'd4
    } state_t;

    state_t     state;
    state_t     state_d;
    state_t     cand;
    state_t     vdir;
    state_t     hdir;
    logic [3:0] prev_in;
    logic [3:0] eff;
    logic [3:0] newbits;
    logic [3:0] dir_d;
    logic [7:0] cnt;
    logic [7:0] cnt_d;
    logic [7:0] cnt_inc;
    logic       vhas;
    logic       hhas;
    logic       vnew;
    logic       hnew;
    logic       held;
    logic       diag_d;

    // Opposite bits on one axis cancel that axis, even if upstream SOCD cleaning slipped.
    always_comb begin
        eff = dirinput;
        if (dirinput[3] && dirinput[2]) eff[3:2] = 2'b00;
        if (dirinput[1] && dirinput[0]) eff[1:0] = 2'b00;
    end

    assign newbits = dirinput & ~prev_in;
    assign vhas    = |eff[3:2];
    assign hhas    = |eff[1:0];
    assign vnew    = |(newbits[3:2] & eff[3:2]);
    assign hnew    = |(newbits[1:0] & eff[1:0]);
    assign vdir    = eff[3] ? ST_UP : ST_DOWN;
    assign hdir    = eff[1] ? ST_LEFT : ST_RIGHT;
    assign held    = (state == vdir) || (state == hdir);
    assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

    always_comb begin
        cand = ST_IDLE;
        if (vhas && !hhas) begin
            cand = vdir;
        end else if (hhas && !vhas) begin
            cand = hdir;
        end else if (vhas && hhas) begin
            case (MODE)
                2'd0: begin
                    if (hnew && !vnew)      cand = hdir;
                    else if (vnew)          cand = vdir;
                    else if (held)          cand = state;
                    else                    cand = vdir;
                end
                2'd1:    cand = held ? state : vdir;
                default: cand = vdir;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= 8'd0;
            prev_in   <= 4'b0000;
            diroutput <= 4'b0000;
            diagonal  <= 1'b0;
        end else if (ce) begin
            state     <= state_d;
            cnt       <= cnt_d;
            prev_in   <= dirinput;
            diroutput <= dir_d;
            diagonal  <= diag_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt_inc;
        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
        end else if (cand == state) begin
            cnt_d = cnt_inc;
        end else if (state == ST_IDLE || cand == ST_IDLE || cnt >= DWELL) begin
            state_d = cand;
            cnt_d   = 8'd0;
        end
    end

    always_comb begin
        dir_d  = 4'b0000;
        diag_d = vhas && hhas;
        if (!enable) begin
            dir_d = eff;
        end else begin
            case (state_d)
                ST_UP:    dir_d = 4'b1000;
                ST_DOWN:  dir_d = 4'b0100;
                ST_LEFT:  dir_d = 4'b0010;
                ST_RIGHT: dir_d = 4'b0001;
                default:  dir_d = 4'b0000;
            endcase
        end
    end

endmodule

// File: tb/tb_joy_fourway_filter.sv
// Scoreboard bench for joy_fourway_filter: three instances cover MODE 0,
// MODE 1 and a DWELL=3 configuration, driven by hand-computed vectors.
module tb_joy_fourway_filter;

    typedef struct {
        int         d;
        bit         chk;
        logic [3:0] dir;
        logic       dg;
        string      nm;
    } exp_t;

    logic       clk;
    logic       rst_s  [3];
    logic       ce_s   [3];
    logic       en_s   [3];
    logic [3:0] din    [3];
    logic [3:0] dout   [3];
    logic       dg     [3];

    exp_t q [$];
    int   checks = 0;
    int   passes = 0;

    joy_fourway_filter #(.MODE(2'd0), .DWELL(8'd0)) u_m0 (
        .clk(clk), .reset(rst_s[0]), .ce(ce_s[0]), .enable(en_s[0]),
        .dirinput(din[0]), .diroutput(dout[0]), .diagonal(dg[0]));

    joy_fourway_filter #(.MODE(2'd1), .DWELL(8'd0)) u_m1 (
        .clk(clk), .reset(rst_s[1]), .ce(ce_s[1]), .enable(en_s[1]),
        .dirinput(din[1]), .diroutput(dout[1]), .diagonal(dg[1]));

    joy_fourway_filter #(.MODE(2'd0), .DWELL(8'd3)) u_dw (
        .clk(clk), .reset(rst_s[2]), .ce(ce_s[2]), .enable(en_s[2]),
        .dirinput(din[2]), .diroutput(dout[2]), .diagonal(dg[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one sample at the falling edge and queue what the DUT must show after the next rise.
    task automatic step(input int d, input logic r, input logic c, input logic e,
                        input logic [3:0] di, input bit chk, input logic [3:0] ed,
                        input logic eg, input string nm);
        exp_t x;
        @(negedge clk);
        rst_s[d] = r;
        ce_s[d]  = c;
        en_s[d]  = e;
        din[d]   = di;
        x.d = d; x.chk = chk; x.dir = ed; x.dg = eg; x.nm = nm;
        q.push_back(x);
    endtask

    task automatic s(input int d, input logic [3:0] di, input logic [3:0] ed,
                     input logic eg, input string nm);
        step(d, 1'b0, 1'b1, 1'b1, di, 1'b1, ed, eg, nm);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                if (x.chk) begin
                    checks++;
                    if (dout[x.d] === x.dir) passes++;
                    else $display("FAIL %s diroutput: got %b want %b", x.nm, dout[x.d], x.dir);
                    checks++;
                    if (dg[x.d] === x.dg) passes++;
                    else $display("FAIL %s diagonal: got %b want %b", x.nm, dg[x.d], x.dg);
                end
            end
        end
    end

    initial begin : stim
        int budget;
        for (int i = 0; i < 3; i++) begin
            rst_s[i] = 1'b1;
            ce_s[i]  = 1'b1;
            en_s[i]  = 1'b1;
            din[i]   = 4'b0000;
        end

        // MODE 0, no dwell
        step(0, 1'b1, 1'b0, 1'b1, 4'b1010, 1'b1, 4'b0000, 1'b0, "m0_reset_ce0");
        s(0, 4'b0000, 4'b0000, 1'b0, "m0_idle");
        s(0, 4'b1000, 4'b1000, 1'b0, "m0_up");
        s(0, 4'b1010, 4'b0010, 1'b1, "m0_newest_left");
        s(0, 4'b0010, 4'b0010, 1'b0, "m0_left_only");
        s(0, 4'b0000, 4'b0000, 1'b0, "m0_release");
        s(0, 4'b0110, 4'b0100, 1'b1, "m0_both_new_vert");
        s(0, 4'b1100, 4'b0000, 1'b0, "m0_socd_vert");
        s(0, 4'b0011, 4'b0000, 1'b0, "m0_socd_horz");
        s(0, 4'b1111, 4'b0000, 1'b0, "m0_socd_all");
        s(0, 4'b0001, 4'b0001, 1'b0, "m0_right");
        s(0, 4'b0101, 4'b0100, 1'b1, "m0_newest_down");
        s(0, 4'b0101, 4'b0100, 1'b1, "m0_keep_down");
        s(0, 4'b1001, 4'b1000, 1'b1, "m0_newest_up");
        step(0, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 4'b1000, 1'b1, "m0_ce0_a");
        step(0, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1, 4'b1000, 1'b1, "m0_ce0_b");
        s(0, 4'b0001, 4'b0001, 1'b0, "m0_ce1_right");
        s(0, 4'b1100, 4'b0000, 1'b0, "m0_ce1_socd");
        step(0, 1'b0, 1'b1, 1'b0, 4'b1010, 1'b1, 4'b1010, 1'b1, "m0_pass_diag");
        step(0, 1'b0, 1'b1, 1'b0, 4'b1100, 1'b1, 4'b0000, 1'b0, "m0_pass_socd");
        step(0, 1'b0, 1'b1, 1'b0, 4'b1010, 1'b1, 4'b1010, 1'b1, "m0_pass_diag2");
        s(0, 4'b1010, 4'b1000, 1'b1, "m0_enable_vert");
        step(0, 1'b0, 1'b1, 1'b0, 4'b0101, 1'b1, 4'b0101, 1'b1, "m0_pass_dr");

        // MODE 1, keep current direction
        step(1, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, "m1_reset");
        s(1, 4'b1000, 4'b1000, 1'b0, "m1_up");
        s(1, 4'b1010, 4'b1000, 1'b1, "m1_keep_up");
        s(1, 4'b0010, 4'b0010, 1'b0, "m1_left");
        s(1, 4'b0000, 4'b0000, 1'b0, "m1_release");
        s(1, 4'b0110, 4'b0100, 1'b1, "m1_idle_diag_vert");
        s(1, 4'b0101, 4'b0100, 1'b1, "m1_keep_down");
        s(1, 4'b1001, 4'b1000, 1'b1, "m1_unheld_vert");

        // MODE 0 with DWELL=3
        step(2, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, "dw_reset");
        s(2, 4'b0000, 4'b0000, 1'b0, "dw_idle");
        s(2, 4'b1000, 4'b1000, 1'b0, "dw_up_enter");
        s(2, 4'b1000, 4'b1000, 1'b0, "dw_up_held");
        s(2, 4'b0010, 4'b1000, 1'b0, "dw_hold_1");
        s(2, 4'b0010, 4'b1000, 1'b0, "dw_hold_2");
        s(2, 4'b0010, 4'b0010, 1'b0, "dw_switch");
        s(2, 4'b1000, 4'b0010, 1'b0, "dw_hold_left");
        s(2, 4'b0000, 4'b0000, 1'b0, "dw_idle_now");
        s(2, 4'b1000, 4'b1000, 1'b0, "dw_from_idle");
        s(2, 4'b0001, 4'b1000, 1'b0, "dw_hold_up");
        s(2, 4'b0000, 4'b0000, 1'b0, "dw_idle_now2");
        s(2, 4'b1000, 4'b1000, 1'b0, "dw_up_again");
        s(2, 4'b0010, 4'b1000, 1'b0, "dw_mid_dwell");
        step(2, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b1, 4'b0000, 1'b0, "dw_reset_a");
        step(2, 1'b1, 1'b0, 1'b1, 4'b0110, 1'b1, 4'b0000, 1'b0, "dw_reset_b");
        s(2, 4'b0110, 4'b0100, 1'b1, "dw_after_reset");
        s(2, 4'b0010, 4'b0100, 1'b0, "dw_hold_down");

        budget = 0;
        while (q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        checks++;
        if (q.size() == 0) passes++;
        else $display("FAIL drain: %0d entries left, want 0", q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/joy_fourway_filter.md
JOY_FOURWAY_FILTER -- requirements
Module: joy_fourway_filter

Interface
REQ-001 SHALL have parameter MODE, default 2'd0, diagonal policy: 0 = newest-axis wins, 1 = keep current direction, 2 = always favour vertical.
REQ-002 SHALL have parameter DWELL, default 8'd0, the minimum number of ce samples a non-idle direction is held before a direct switch to another non-idle direction (0 = no dwell).
REQ-003 SHALL have port clk, input, 1 bit, system clock, with all state updating on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port ce, input, 1 bit, sample enable; state and outputs update only on clk edges where ce=1.
REQ-006 SHALL have port enable, input, 1 bit: 1 = four-way filtering, 0 = registered pass-through.
REQ-007 SHALL have port dirinput, input, 4 bits, {up,down,left,right}, SOCD-cleaned and active-high.
REQ-008 SHALL have port diroutput, output, 4 bits, {up,down,left,right}, registered; in four-way mode at most one bit is set.
REQ-009 SHALL have port diagonal, output, 1 bit, registered; 1 when the last sample held one vertical bit and one horizontal bit.

Function
REQ-010 SHALL keep a state register with states IDLE, UP, DOWN, LEFT, RIGHT; diroutput is the one-hot encoding of the state (IDLE = 4'b0000).
REQ-011 SHALL register prev_in <= dirinput on every ce sample; new = dirinput & ~prev_in.
REQ-012 SHALL treat an axis with both opposite bits set as released on that axis (defensive SOCD-zero).
REQ-013 SHALL form the candidate from the effective input:
- no bits set -> IDLE
- exactly one bit set -> that direction
- one vertical and one horizontal bit set -> diagonal resolution per REQ-014..016
REQ-014 For MODE 0, on a diagonal:
- exactly one axis has a new bit -> that axis's direction
- both axes new in the same sample -> vertical
- neither new -> current state if it is one of the two held directions, else vertical
REQ-015 For MODE 1, on a diagonal: current state if it is one of the two held directions, else vertical.
REQ-016 For MODE 2, on a diagonal: always vertical.
REQ-017 SHALL keep an 8-bit dwell counter: cleared on every state change; on each ce sample with no state change it increments, saturating at 255.
REQ-018 SHALL take transitions to or from IDLE on the same sample, independent of the dwell counter.
REQ-019 SHALL take a transition between two different non-idle states only if the counter is >= DWELL; otherwise the state holds, and the counter keeps incrementing until the switch is allowed.
REQ-020 SHALL apply a candidate equal to the current state as no change.
REQ-021 SHALL give a latency of 1 clk: outputs reflect dirinput sampled at the ce=1 edge; with ce=0, all registers hold.
REQ-022 With enable=0: on each ce sample diroutput <= effective input (REQ-012), state <= IDLE, and the counter <= 0.
REQ-023 SHALL resolve an enable 0->1 change from IDLE as in REQ-013, with no dwell applied.
REQ-024 SHALL compute diagonal in both enable modes.

Reset
REQ-025 SHALL, while reset=1 at a clk edge (regardless of ce), set state to IDLE, diroutput to 4'b0000, diagonal to 0, prev_in to 4'b0000 and the counter to 0.
REQ-026 SHALL apply reset mid-transition or mid-dwell with no residual history; the first sample after reset treats all held bits as new.

Verification
REQ-027 With MODE=0, DWELL=0, ce=1: 0000 -> 1000 -> 1010, expect diroutput 1000 then 0010, diagonal=1 on the second sample; then 0010, expect 0010.
REQ-028 With MODE=1: 1000 -> 1010, expect diroutput to stay 1000; then 0010, expect 0010; then 0000, expect 0000 in 1 clk.
REQ-029 With MODE=0, DWELL=3: 1000 held 1 sample, then 0010, expect 1000 for 2 more samples and 0010 on the 3rd; 0000 at any point gives 0000 immediately.
REQ-030 With ce toggling 1-0-0-1 and input changed during the ce=0 cycles, expect outputs to change only at the ce=1 edges; with input 1100 expect 0000.
REQ-031 With enable=0 and input 1010, expect diroutput 1010 and diagonal=1; then enable=1 with 1010 held, expect 1000 in MODE 0 (vertical, nothing new).
REQ-032 Assert reset during a dwell, then release with input 0110 held: expect 0000 during reset and 0100 on the first sample after release (MODE 0, both axes new -> vertical).
